para_mem_ctrl: RTL and testbench
================================

Name: para_mem_ctrl

Overview:
Request/response access controller that sits directly upstream of the 8x4 parameterised memory and drives its address, data_in and write_enable pins. Accepts read, write and fill commands over a valid/ready request channel. Sequences the memory pins cycle by cycle and returns read data or completion status over a valid/ready response channel. Fill writes one value to every location and is used for clear/initialisation.

Parameters:
ADDR_WIDTH, 3, memory address width; must match the memory instance.
DATA_WIDTH, 4, memory word width; must match the memory instance.
DEPTH, 8, number of valid locations; 1 <= DEPTH <= 2**ADDR_WIDTH.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  controller accepts a request; high only in IDLE.
req_op  in  2  00 read, 01 write, 10 fill, 11 illegal.
req_addr  in  ADDR_WIDTH  target address; ignored for fill.
req_wdata  in  DATA_WIDTH  write data, or fill value for fill.
rsp_valid  out  1  response present; held until accepted.
rsp_ready  in  1  consumer accepts the response.
rsp_rdata  out  DATA_WIDTH  read data; 0 for write, fill and error responses.
rsp_err  out  1  request rejected (address >= DEPTH or op 11).
mem_address  out  ADDR_WIDTH  to memory address.
mem_data_in  out  DATA_WIDTH  to memory data_in.
mem_write_enable  out  1  to memory write_enable.
mem_data_out  in  DATA_WIDTH  from memory data_out.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state IDLE; rsp_valid, rsp_rdata, rsp_err, mem_address, mem_data_in, mem_write_enable, busy and the fill counter are all 0. req_ready is 1 from the first cycle after reset deasserts.
- Request acceptance: a request is accepted when req_valid and req_ready are both high (cycle 0). req_op, req_addr and req_wdata are registered at that edge.
- States: IDLE, WR, RD, FILL, RESP.
- IDLE transitions on accept:
  - error (op 11, or read/write with addr >= DEPTH) -> RESP with rsp_err=1; no memory access.
  - read -> RD.
  - write -> WR.
  - fill -> FILL with counter=0.
- WR (cycle 1): mem_write_enable=1 for exactly one cycle, with mem_address=addr and mem_data_in=wdata; then RESP.
- RD (cycle 1): mem_write_enable=0, mem_address=addr. At the end of the cycle mem_data_out is captured into rsp_rdata; then RESP.
- FILL: for DEPTH consecutive cycles, mem_write_enable=1, mem_address=counter, mem_data_in=fill value. The counter increments each cycle. Termination is the compare counter==DEPTH-1, never a natural wrap, so non-power-of-two DEPTH is correct. Then RESP.
- RESP: rsp_valid=1. Timing: cycle 2 after accept for read/write, cycle 1 for errors, cycle DEPTH+1 for fill.
  - rsp_rdata and rsp_err stay stable while rsp_ready is low.
  - On rsp_valid && rsp_ready -> IDLE with rsp_valid=0.
  - req_ready returns the following cycle, so there is no same-cycle response/request overlap.
- Outside WR and FILL, mem_write_enable=0. mem_address and mem_data_in hold their last values and are never driven with out-of-range addresses.
- Reset mid-operation: on the edge where rst=1, all registers return to their reset values. mem_write_enable is therefore 0 from the next cycle, and any pending response is dropped. Memory contents after an aborted fill are partially updated; this is permitted.
- Reset dominates every other event in the same cycle.

Decomposition:
- Shared package para_mem_pkg holds:
  - op encodings OP_READ=2'b00, OP_WRITE=2'b01, OP_FILL=2'b10, OP_ILLEGAL=2'b11;
  - the state enum (IDLE, WR, RD, FILL, RESP).
- No sub-module; the fill counter lives inline. The top-level test wrapper instantiates para_mem_ctrl together with para_mem8x4.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 -> req_ready=1, rsp_valid=0, mem_write_enable=0, mem_address=0.
- Write addr 3, data 4'hA, then read addr 3 -> mem_write_enable high exactly one cycle with address 3 and data A, rsp_valid at cycle 2 with rsp_err=0. The read returns rsp_rdata=4'hA at cycle 2.
- Fill with 4'h5 (DEPTH=8) -> mem_write_enable high 8 consecutive cycles, addresses 0..7, rsp_valid at cycle 9. Subsequent reads of addresses 0 and 7 return 4'h5.
- DEPTH=6 instance -> write to addr 6 gives no write pulse and rsp_err=1 at cycle 1. Fill gives exactly 6 pulses, addresses 0..5; address 6 is never driven.
- Backpressure: hold rsp_ready=0 for 5 cycles after a read of 4'hA -> rsp_valid, rsp_rdata=4'hA and rsp_err stay stable and req_ready=0. A concurrent req_valid is not accepted.
- Reset during fill at the 4th pulse -> mem_write_enable=0 from the next cycle, busy=0, rsp_valid never asserted, req_ready=1 once rst falls.

Source files
------------

// File: rtl/para_mem_pkg.sv
// rtl/para_mem_pkg.sv - shared op encodings and controller state type
package para_mem_pkg;

   localparam logic [1:0] OP_READ    = 2'b00;
   localparam logic [1:0] OP_WRITE   = 2'b01;
   localparam logic [1:0] OP_FILL    = 2'b10;
   localparam logic [1:0] OP_ILLEGAL = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD,
      FILL,
      RESP
   } state_t;

endpackage

// File: rtl/para_mem_ctrl_if.sv
// rtl/para_mem_ctrl_if.sv - request/response channel bundle for para_mem_ctrl
interface para_mem_ctrl_if #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 4
);
   logic                  req_valid;
   logic                  req_ready;
   logic [1:0]            req_op;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;

   // requester side
   modport master (
      output req_valid, req_op, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   // controller side
   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/para_mem_ctrl.sv
// rtl/para_mem_ctrl.sv - read/write/fill sequencer for the parameterised memory
module para_mem_ctrl
   import para_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 4,
   parameter int DEPTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   para_mem_ctrl_if.slave        bus,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   output logic                  mem_write_enable,
   input  logic [DATA_WIDTH-1:0] mem_data_out,
   output logic                  busy
);

   // Last fill address; fill ends on this compare, never on counter wrap.
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   // One extra bit so DEPTH == 2**ADDR_WIDTH compares correctly.
   localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

   state_t                state;
   state_t                state_next;
   logic                  accept;
   logic                  req_err;
   logic [ADDR_WIDTH-1:0] fill_cnt;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state decode, request classification and status outputs
   always_comb begin
      state_next    = state;
      accept        = 1'b0;
      req_err       = 1'b0;
      bus.req_ready = (state == IDLE);
      bus.rsp_valid = (state == RESP);
      busy          = (state != IDLE);
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               accept  = 1'b1;
               req_err = (bus.req_op == OP_ILLEGAL) ||
                         ((bus.req_op != OP_FILL) && ({1'b0, bus.req_addr} >= DEPTH_EXT));
               if (req_err)                    state_next = RESP;
               else if (bus.req_op == OP_READ)  state_next = RD;
               else if (bus.req_op == OP_WRITE) state_next = WR;
               else                             state_next = FILL;
            end
         end
         WR:      state_next = RESP;
         RD:      state_next = RESP;
         FILL:    if (fill_cnt == LAST_ADDR) state_next = RESP;
         RESP:    if (bus.rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Memory pin sequencing, fill counter and response capture
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_address      <= '0;
         mem_data_in      <= '0;
         mem_write_enable <= 1'b0;
         fill_cnt         <= '0;
         bus.rsp_rdata    <= '0;
         bus.rsp_err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  bus.rsp_rdata <= '0;
                  bus.rsp_err   <= req_err;
                  // Errors never touch the memory pins, so no out-of-range address escapes.
                  if (!req_err) begin
                     if (bus.req_op == OP_WRITE) begin
                        mem_address      <= bus.req_addr;
                        mem_data_in      <= bus.req_wdata;
                        mem_write_enable <= 1'b1;
                     end else if (bus.req_op == OP_READ) begin
                        mem_address      <= bus.req_addr;
                     end else begin
                        fill_cnt         <= '0;
                        mem_address      <= '0;
                        mem_data_in      <= bus.req_wdata;
                        mem_write_enable <= 1'b1;
                     end
                  end
               end
            end
            WR: mem_write_enable <= 1'b0;
            RD: bus.rsp_rdata    <= mem_data_out;
            FILL: begin
               if (fill_cnt == LAST_ADDR) begin
                  mem_write_enable <= 1'b0;
               end else begin
                  fill_cnt    <= fill_cnt + 1'b1;
                  mem_address <= fill_cnt + 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_rdata <= '0;
                  bus.rsp_err   <= 1'b0;
               end
            end
            default: mem_write_enable <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_para_mem_ctrl.sv
// tb/tb_para_mem_ctrl.sv - scoreboard bench for para_mem_ctrl at DEPTH 8 and 6
module tb_para_mem_ctrl;
   import para_mem_pkg::*;

   typedef struct {
      int rdata;
      int err;
      int lat;
      int start;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   logic       rst8, rst6;
   logic [2:0] ma8, ma6;
   logic [3:0] md8, md6, dout8, dout6;
   logic       we8, we6, busy8, busy6;
   logic [3:0] mem8 [8];
   logic [3:0] mem6 [8];

   para_mem_ctrl_if #(.ADDR_WIDTH(3), .DATA_WIDTH(4)) b8 ();
   para_mem_ctrl_if #(.ADDR_WIDTH(3), .DATA_WIDTH(4)) b6 ();

   para_mem_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(4), .DEPTH(8)) dut8 (
      .clk(clk), .rst(rst8), .bus(b8.slave), .mem_address(ma8), .mem_data_in(md8),
      .mem_write_enable(we8), .mem_data_out(dout8), .busy(busy8));

   para_mem_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(4), .DEPTH(6)) dut6 (
      .clk(clk), .rst(rst6), .bus(b6.slave), .mem_address(ma6), .mem_data_in(md6),
      .mem_write_enable(we6), .mem_data_out(dout6), .busy(busy6));

   // 8x4 memories: synchronous write, asynchronous read
   always @(posedge clk) if (we8) mem8[ma8] <= md8;
   always @(posedge clk) if (we6) mem6[ma6] <= md6;
   assign dout8 = mem8[ma8];
   assign dout6 = mem6[ma6];

   exp_t       q8[$], q6[$];
   exp_t       cur8, cur6;
   bit         seen8 = 0, seen6 = 0, bad8 = 0, bad6 = 0;
   logic [7:0] log8[$], log6[$];
   int         max6 = 0;

   // DEPTH=8 response monitor and write-pulse logger
   always @(negedge clk) begin
      if (we8) log8.push_back({1'b0, ma8, md8});
      if (rst8) begin
         seen8 = 0;
      end else if (b8.rsp_valid) begin
         if (!seen8) begin
            seen8 = 1;
            bad8  = (q8.size() == 0);
            if (bad8) chk("rsp8_unexpected", 1, 0);
            else begin
               cur8 = q8.pop_front();
               chk("rsp8_latency", cyc - cur8.start, cur8.lat);
            end
         end
         if (!bad8) begin
            chk("rsp8_rdata", int'(b8.rsp_rdata), cur8.rdata);
            chk("rsp8_err", int'(b8.rsp_err), cur8.err);
         end
         if (b8.rsp_ready) seen8 = 0;
      end
   end

   // DEPTH=6 response monitor, write-pulse logger and address range tracker
   always @(negedge clk) begin
      if (we6) log6.push_back({1'b0, ma6, md6});
      if (int'(ma6) > max6) max6 = int'(ma6);
      if (rst6) begin
         seen6 = 0;
      end else if (b6.rsp_valid) begin
         if (!seen6) begin
            seen6 = 1;
            bad6  = (q6.size() == 0);
            if (bad6) chk("rsp6_unexpected", 1, 0);
            else begin
               cur6 = q6.pop_front();
               chk("rsp6_latency", cyc - cur6.start, cur6.lat);
            end
         end
         if (!bad6) begin
            chk("rsp6_rdata", int'(b6.rsp_rdata), cur6.rdata);
            chk("rsp6_err", int'(b6.rsp_err), cur6.err);
         end
         if (b6.rsp_ready) seen6 = 0;
      end
   end

   task automatic drive(input int d, input logic v, input logic [1:0] op,
                        input logic [2:0] a, input logic [3:0] w);
      if (d == 0) begin
         b8.req_valid = v; b8.req_op = op; b8.req_addr = a; b8.req_wdata = w;
      end else begin
         b6.req_valid = v; b6.req_op = op; b6.req_addr = a; b6.req_wdata = w;
      end
   endtask

   function automatic bit rdy(input int d);
      return (d == 0) ? b8.req_ready : b6.req_ready;
   endfunction

   task automatic issue(input int d, input logic [1:0] op, input logic [2:0] a,
                        input logic [3:0] w, input int erd, input int eerr,
                        input int elat, input bit push);
      exp_t e;
      int   n;
      @(negedge clk);
      drive(d, 1'b1, op, a, w);
      n = 0;
      while (!rdy(d) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!rdy(d)) begin
         chk("accept_timeout", 0, 1);
      end else if (push) begin
         e.rdata = erd; e.err = eerr; e.lat = elat; e.start = cyc;
         if (d == 0) q8.push_back(e);
         else        q6.push_back(e);
      end
      @(posedge clk);
      #1 drive(d, 1'b0, op, a, w);
   endtask

   task automatic wait_done(input int d);
      int n;
      bit idle;
      n    = 0;
      idle = 0;
      while (!idle && n < 100) begin
         @(negedge clk);
         #1;
         n++;
         if (d == 0) idle = (q8.size() == 0) && !seen8 && b8.req_ready;
         else        idle = (q6.size() == 0) && !seen6 && b6.req_ready;
      end
      if (!idle) chk("done_timeout", 0, 1);
      #1;
   endtask

   initial begin
      int k, n, pulses;
      rst8 = 1'b1; rst6 = 1'b1;
      drive(0, 1'b0, OP_READ, 3'd0, 4'd0);
      drive(1, 1'b0, OP_READ, 3'd0, 4'd0);
      b8.rsp_ready = 1'b1; b6.rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst8 = 1'b0; rst6 = 1'b0;

      // reset state
      @(negedge clk);
      chk("rst_req_ready8", int'(b8.req_ready), 1);
      chk("rst_rsp_valid8", int'(b8.rsp_valid), 0);
      chk("rst_we8", int'(we8), 0);
      chk("rst_addr8", int'(ma8), 0);
      chk("rst_busy8", int'(busy8), 0);
      chk("rst_req_ready6", int'(b6.req_ready), 1);
      chk("rst_we6", int'(we6), 0);

      // write 3 <- A, single pulse
      log8.delete();
      issue(0, OP_WRITE, 3'd3, 4'hA, 0, 0, 2, 1);
      wait_done(0);
      chk("wr_pulses", log8.size(), 1);
      if (log8.size() > 0) chk("wr_addr_data", int'(log8[0]), 8'h3A);

      // read 3 -> A, no pulse
      log8.delete();
      issue(0, OP_READ, 3'd3, 4'h0, 4'hA, 0, 2, 1);
      wait_done(0);
      chk("rd_pulses", log8.size(), 0);

      // fill with 5: eight pulses over addresses 0..7
      log8.delete();
      issue(0, OP_FILL, 3'd2, 4'h5, 0, 0, 9, 1);
      wait_done(0);
      chk("fill8_pulses", log8.size(), 8);
      for (int i = 0; i < 8 && i < log8.size(); i++)
         chk("fill8_addr_data", int'(log8[i]), (i << 4) | 5);
      issue(0, OP_READ, 3'd0, 4'h0, 4'h5, 0, 2, 1);
      issue(0, OP_READ, 3'd7, 4'h0, 4'h5, 0, 2, 1);
      wait_done(0);

      // backpressure on a read of A with a competing request held
      issue(0, OP_WRITE, 3'd3, 4'hA, 0, 0, 2, 1);
      wait_done(0);
      b8.rsp_ready = 1'b0;
      issue(0, OP_READ, 3'd3, 4'h0, 4'hA, 0, 2, 1);
      @(negedge clk);
      drive(0, 1'b1, OP_WRITE, 3'd0, 4'hF);
      pulses = 0;
      repeat (5) begin
         @(negedge clk);
         chk("bp_req_ready", int'(b8.req_ready), 0);
         chk("bp_rsp_valid", int'(b8.rsp_valid), 1);
         if (we8) pulses++;
      end
      drive(0, 1'b0, OP_WRITE, 3'd0, 4'hF);
      b8.rsp_ready = 1'b1;
      wait_done(0);
      chk("bp_no_accept_pulses", pulses, 0);
      issue(0, OP_READ, 3'd0, 4'h0, 4'h5, 0, 2, 1);
      wait_done(0);

      // illegal op: immediate error, no memory access
      log8.delete();
      issue(0, OP_ILLEGAL, 3'd1, 4'h9, 0, 1, 1, 1);
      wait_done(0);
      chk("illegal_pulses", log8.size(), 0);

      // reset during fill at the fourth pulse
      issue(0, OP_FILL, 3'd0, 4'h7, 0, 0, 0, 0);
      k = 0; n = 0;
      while (k < 4 && n < 20) begin
         @(negedge clk);
         if (we8) k++;
         n++;
      end
      chk("abort_pulse_count", k, 4);
      rst8 = 1'b1;
      @(negedge clk);
      chk("abort_we", int'(we8), 0);
      chk("abort_busy", int'(busy8), 0);
      chk("abort_rsp_valid", int'(b8.rsp_valid), 0);
      @(posedge clk);
      #1 rst8 = 1'b0;
      @(negedge clk);
      chk("abort_req_ready", int'(b8.req_ready), 1);
      repeat (10) @(negedge clk);
      chk("abort_still_idle", int'(busy8), 0);
      issue(0, OP_READ, 3'd1, 4'h0, 4'h7, 0, 2, 1);
      issue(0, OP_READ, 3'd5, 4'h0, 4'h5, 0, 2, 1);
      wait_done(0);

      // DEPTH=6: out-of-range write rejected, fill covers 0..5 only
      log6.delete();
      issue(1, OP_WRITE, 3'd6, 4'h9, 0, 1, 1, 1);
      wait_done(1);
      chk("d6_oob_pulses", log6.size(), 0);
      issue(1, OP_READ, 3'd7, 4'h0, 0, 1, 1, 1);
      wait_done(1);
      log6.delete();
      issue(1, OP_FILL, 3'd7, 4'h2, 0, 0, 7, 1);
      wait_done(1);
      chk("fill6_pulses", log6.size(), 6);
      for (int i = 0; i < 6 && i < log6.size(); i++)
         chk("fill6_addr_data", int'(log6[i]), (i << 4) | 2);
      chk("fill6_max_addr", max6, 5);
      issue(1, OP_READ, 3'd5, 4'h0, 4'h2, 0, 2, 1);
      wait_done(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
